// File: rtl/dco_ctrl_if.sv
// Control/status bundle between the ADPLL loop logic and the DCO sequencer.
// The slave side is the controller; the master side drives loop events and observes DCO codes.
interface dco_ctrl_if;
  logic        en;
  logic        tune_valid;
  logic [7:0]  tune_word;
  logic        lock_pvt;
  logic        lock_acq;
  logic        relock;
  logic        pd;
  logic [1:0]  osc_gain;
  logic [4:0]  c_l_r_all;
  logic [4:0]  c_l_row;
  logic [4:0]  c_l_col;
  logic [15:0] c_m_r_all;
  logic [15:0] c_m_row;
  logic [15:0] c_m_col;
  logic [15:0] c_s_r_all;
  logic [15:0] c_s_row;
  logic [15:0] c_s_col;
  logic [2:0]  mode;

  modport slave (
    input  en, tune_valid, tune_word, lock_pvt, lock_acq, relock,
    output pd, osc_gain, c_l_r_all, c_l_row, c_l_col, c_m_r_all, c_m_row, c_m_col,
           c_s_r_all, c_s_row, c_s_col, mode
  );

  modport master (
    output en, tune_valid, tune_word, lock_pvt, lock_acq, relock,
    input  pd, osc_gain, c_l_r_all, c_l_row, c_l_col, c_m_r_all, c_m_row, c_m_col,
           c_s_r_all, c_s_row, c_s_col, mode
  );
endinterface

// File: rtl/dco_ctrl.sv
// Tank-capacitor DCO sequencer: power-up, PVT/ACQ/TRK mode walk and per-mode steering
// of loop-filter tuning words into the L/M/S capacitor bank select codes.
module dco_ctrl #(
  parameter int unsigned STARTUP_CYC = 64,
  parameter logic [1:0]  GAIN_START  = 2'd3,
  parameter logic [1:0]  GAIN_RUN    = 2'd1,
  parameter logic [4:0]  L_INIT      = 5'd12,
  parameter logic [7:0]  M_INIT      = 8'd128,
  parameter logic [7:0]  S_INIT      = 8'd128
) (
  input logic        clk,
  input logic        rst,
  dco_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStartup = 3'd1,
    StPvt     = 3'd2,
    StAcq     = 3'd3,
    StTrk     = 3'd4
  } state_e;

  localparam int unsigned    CntW    = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STARTUP_CYC - 1);

  // Thermometer split of a count into {r_all, row, col}; q groups fully on, r cells in group q.
  function automatic logic [14:0] enc_l(input logic [4:0] v);
    logic [4:0] r_all, row, col;
    int q, r;
    q = int'(v) / 5;
    r = int'(v) % 5;
    for (int i = 0; i < 5; i++) begin
      r_all[i] = (i < q);
      row[i]   = (i == q);
      col[i]   = (i < r);
    end
    return {r_all, row, col};
  endfunction

  function automatic logic [47:0] enc_ms(input logic [7:0] v);
    logic [15:0] r_all, row, col;
    int q, r;
    q = int'(v[7:4]);
    r = int'(v[3:0]);
    for (int i = 0; i < 16; i++) begin
      r_all[i] = (i < q);
      row[i]   = (i == q);
      col[i]   = (i < r);
    end
    return {r_all, row, col};
  endfunction

  state_e          st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      l_q, l_d;
  logic [7:0]      m_q, m_d;
  logic [7:0]      s_q, s_d;
  logic [4:0]      l_word;
  logic [1:0]      gain_d;

  assign l_word = (bus.tune_word > 8'd25) ? 5'd25 : bus.tune_word[4:0];

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    l_d   = l_q;
    m_d   = m_q;
    s_d   = s_q;
    if (!bus.en) begin
      st_d  = StIdle;
      cnt_d = '0;
      l_d   = L_INIT;
      m_d   = M_INIT;
      s_d   = S_INIT;
    end else begin
      unique case (st_q)
        StIdle: begin
          st_d  = StStartup;
          cnt_d = '0;
        end
        StStartup: begin
          if (cnt_q == CntLast) begin
            st_d  = StPvt;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StPvt: begin
          if (bus.tune_valid) l_d = l_word;
          if (bus.lock_pvt) st_d = StAcq;
        end
        StAcq, StTrk: begin
          if (bus.tune_valid) begin
            if (st_q == StAcq) m_d = bus.tune_word;
            else               s_d = bus.tune_word;
          end
          // Relock discards fine/medium state but keeps the coarse L setting.
          if (bus.relock) begin
            st_d = StPvt;
            m_d  = M_INIT;
            s_d  = S_INIT;
          end else if (st_q == StAcq && bus.lock_acq) begin
            st_d = StTrk;
          end
        end
        default: st_d = StIdle;
      endcase
    end
  end

  always_comb begin
    gain_d = GAIN_RUN;
    if (st_d == StIdle)         gain_d = 2'd0;
    else if (st_d == StStartup) gain_d = GAIN_START;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= StIdle;
      cnt_q        <= '0;
      l_q          <= L_INIT;
      m_q          <= M_INIT;
      s_q          <= S_INIT;
      bus.pd       <= 1'b1;
      bus.osc_gain <= 2'd0;
      bus.mode     <= 3'd0;
      {bus.c_l_r_all, bus.c_l_row, bus.c_l_col} <= enc_l(L_INIT);
      {bus.c_m_r_all, bus.c_m_row, bus.c_m_col} <= enc_ms(M_INIT);
      {bus.c_s_r_all, bus.c_s_row, bus.c_s_col} <= enc_ms(S_INIT);
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      l_q          <= l_d;
      m_q          <= m_d;
      s_q          <= s_d;
      bus.pd       <= (st_d == StIdle);
      bus.osc_gain <= gain_d;
      bus.mode     <= st_d;
      {bus.c_l_r_all, bus.c_l_row, bus.c_l_col} <= enc_l(l_d);
      {bus.c_m_r_all, bus.c_m_row, bus.c_m_col} <= enc_ms(m_d);
      {bus.c_s_r_all, bus.c_s_row, bus.c_s_col} <= enc_ms(s_d);
    end
  end

endmodule

// File: tb/tb_dco_ctrl.sv
// Scoreboard bench for dco_ctrl: the driver pushes hand-computed expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_dco_ctrl;

  typedef struct {
    string       tag;
    logic [2:0]  mode;
    logic        pd;
    logic [1:0]  gain;
    logic [14:0] l;
    logic [47:0] m;
    logic [47:0] s;
  } exp_t;

  localparam logic [14:0] L0   = {5'b00000, 5'b00001, 5'b00000};
  localparam logic [14:0] L7   = {5'b00001, 5'b00010, 5'b00011};
  localparam logic [14:0] L12  = {5'b00011, 5'b00100, 5'b00011};
  localparam logic [14:0] L25  = {5'b11111, 5'b00000, 5'b00000};
  localparam logic [47:0] M128 = {16'h00FF, 16'h0100, 16'h0000};
  localparam logic [47:0] M255 = {16'h7FFF, 16'h8000, 16'h7FFF};
  localparam logic [47:0] M17  = {16'h0001, 16'h0002, 16'h0001};

  logic clk = 1'b0;
  logic rst;
  dco_ctrl_if bus ();

  dco_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Current expectation, set by hand before each driven cycle.
  logic [2:0]  e_mode;
  logic        e_pd;
  logic [1:0]  e_gain;
  logic [14:0] e_l;
  logic [47:0] e_m;
  logic [47:0] e_s;

  task automatic check(input string tag, input string what, input logic [47:0] act,
                       input logic [47:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s/%s: got %h expected %h", tag, what, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.tag, "mode_pd_gain", 48'({bus.mode, bus.pd, bus.osc_gain}),
            48'({e.mode, e.pd, e.gain}));
      check(e.tag, "l_bank", 48'({bus.c_l_r_all, bus.c_l_row, bus.c_l_col}), 48'(e.l));
      check(e.tag, "m_bank", {bus.c_m_r_all, bus.c_m_row, bus.c_m_col}, e.m);
      check(e.tag, "s_bank", {bus.c_s_r_all, bus.c_s_row, bus.c_s_col}, e.s);
    end
  end

  task automatic set_exp(input logic [2:0] mode, input logic pd, input logic [1:0] gain,
                         input logic [14:0] l, input logic [47:0] m, input logic [47:0] s);
    e_mode = mode; e_pd = pd; e_gain = gain; e_l = l; e_m = m; e_s = s;
  endtask

  task automatic cycle(input string tag, input logic r, input logic en, input logic tv,
                       input logic [7:0] tw, input logic lp, input logic la, input logic rl);
    exp_t e;
    rst = r; bus.en = en; bus.tune_valid = tv; bus.tune_word = tw;
    bus.lock_pvt = lp; bus.lock_acq = la; bus.relock = rl;
    @(posedge clk);
    #1;
    e.tag = tag; e.mode = e_mode; e.pd = e_pd; e.gain = e_gain;
    e.l = e_l; e.m = e_m; e.s = e_s;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic startup(input string tag);
    set_exp(3'd1, 1'b0, 2'd3, L12, M128, M128);
    cycle({tag, "_e0"}, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 64; i++)
      cycle({tag, "_st"}, 1'b0, 1'b1, (i % 8) == 3, 8'(i * 4), 1'b1, 1'b1, 1'b1);
    set_exp(3'd2, 1'b0, 2'd1, L12, M128, M128);
    cycle({tag, "_e64"}, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and IDLE.
    set_exp(3'd0, 1'b1, 2'd0, L12, M128, M128);
    cycle("rst0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle("rst1", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle("idle_tv", 1'b0, 1'b0, 1'b1, 8'h07, 1'b1, 1'b1, 1'b1);

    startup("su1");

    // PVT encoding with clamping.
    set_exp(3'd2, 1'b0, 2'd1, L0, M128, M128);
    cycle("pvt_0", 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    e_l = L7;
    cycle("pvt_7", 1'b0, 1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
    e_l = L25;
    cycle("pvt_25", 1'b0, 1'b1, 1'b1, 8'd25, 1'b0, 1'b0, 1'b0);
    cycle("pvt_31", 1'b0, 1'b1, 1'b1, 8'd31, 1'b0, 1'b0, 1'b0);
    cycle("pvt_ff", 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    cycle("pvt_hold", 1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1, 1'b1);

    // ACQ / TRK.
    e_mode = 3'd3;
    cycle("lock_pvt", 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    e_m = M255;
    cycle("acq_255", 1'b0, 1'b1, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
    e_mode = 3'd4;
    cycle("lock_acq", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    e_s = M17;
    cycle("trk_17", 1'b0, 1'b1, 1'b1, 8'd17, 1'b1, 1'b1, 1'b0);

    // Relock keeps L, restores M/S.
    set_exp(3'd2, 1'b0, 2'd1, L25, M128, M128);
    cycle("relock", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);

    // en=0 beats lock_acq in ACQ.
    e_mode = 3'd3;
    cycle("lock_pvt2", 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    set_exp(3'd0, 1'b1, 2'd0, L12, M128, M128);
    cycle("en0_lock", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);

    startup("su2");

    // Tune word and lock_pvt on the same edge.
    set_exp(3'd3, 1'b0, 2'd1, L25, M128, M128);
    cycle("tv_lock", 1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0);
    e_m = M17;
    cycle("acq_17", 1'b0, 1'b1, 1'b1, 8'd17, 1'b0, 1'b0, 1'b0);

    // Synchronous reset mid-operation.
    set_exp(3'd0, 1'b1, 2'd0, L12, M128, M128);
    cycle("rst_mid", 1'b1, 1'b1, 1'b1, 8'd9, 1'b0, 1'b1, 1'b0);
    set_exp(3'd1, 1'b0, 2'd3, L12, M128, M128);
    cycle("post_rst", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
